// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU I/O handshake controller.
package cpu_pkg;

   localparam int IO_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_IN  = 2'd1,
      WAIT_OUT = 2'd2,
      DONE     = 2'd3
   } io_state_t;

endpackage

// File: rtl/io_timeout_cnt.sv
// Saturating handshake timeout counter; expires on the TO_CYC-th enabled cycle
// after a clear. TO_CYC = 0 disables expiry.
module io_timeout_cnt #(
   parameter int TO_CYC = 1000,
   parameter int CNT_W  = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LAST = (TO_CYC == 0) ? '0 : CNT_W'(TO_CYC - 1);
   localparam bit               ARMED = (TO_CYC != 0);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && ARMED && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = ARMED && i_en && (r_cnt == LAST);

endmodule

// File: rtl/io_handshake_ctrl.sv
// Turns single-cycle CPU I/O instructions into valid/ready handshakes with the
// game peripherals, stalling the CPU until each transfer completes or times out.
module io_handshake_ctrl
   import cpu_pkg::*;
#(
   parameter int                DATA_W  = IO_DATA_W,
   parameter int                TO_CYC  = 1000,
   parameter int                CNT_W   = 16,
   parameter logic [DATA_W-1:0] TO_DATA = DATA_W'(8'hFF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_in,
   input  logic              s_out,
   input  logic [DATA_W-1:0] cpu_out_data,
   output logic [DATA_W-1:0] cpu_in_data,
   output logic              stall,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              timeout_err,
   output logic              busy
);

   io_state_t         r_state;
   logic [DATA_W-1:0] r_data_q;
   logic [DATA_W-1:0] r_out_data;
   logic              r_to_err;
   logic              w_wait;
   logic              w_expired;

   assign w_wait = (r_state == WAIT_IN) || (r_state == WAIT_OUT);

   // Counter is held clear outside the WAIT states, so every WAIT entry starts at 0.
   io_timeout_cnt #(
      .TO_CYC (TO_CYC),
      .CNT_W  (CNT_W)
   ) u_to_cnt (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_clr     (~w_wait),
      .i_en      (w_wait),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_data_q   <= '0;
         r_out_data <= '0;
         r_to_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s_in) begin
                  r_state <= WAIT_IN;
               end else if (s_out) begin
                  r_out_data <= cpu_out_data;
                  r_state    <= WAIT_OUT;
               end
            end
            WAIT_IN: begin
               if (in_valid) begin
                  r_data_q <= in_data;
                  r_state  <= DONE;
               end else if (w_expired) begin
                  r_data_q <= TO_DATA;
                  r_to_err <= 1'b1;
                  r_state  <= DONE;
               end
            end
            WAIT_OUT: begin
               if (out_ready) begin
                  r_state <= DONE;
               end else if (w_expired) begin
                  r_to_err <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // The request cycle stalls combinationally; reset masks it so stall drops at once.
   assign stall       = ~reset & (w_wait | ((r_state == IDLE) & (s_in | s_out)));
   assign in_ready    = (r_state == WAIT_IN);
   assign out_valid   = (r_state == WAIT_OUT);
   assign busy        = (r_state != IDLE);
   assign cpu_in_data = r_data_q;
   assign out_data    = r_out_data;
   assign timeout_err = r_to_err;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Scoreboard bench for io_handshake_ctrl: a default-timeout instance for normal
// transfers and a TO_CYC=4 instance for the timeout path.
module tb_io_handshake_ctrl;

   logic       clk = 1'b0;
   logic       reset;

   logic       s_in, s_out, in_valid, out_ready;
   logic [7:0] cpu_out_data, in_data;
   logic [7:0] cpu_in_data, out_data;
   logic       stall, in_ready, out_valid, timeout_err, busy;

   logic       t_s_in, t_s_out, t_in_valid, t_out_ready;
   logic [7:0] t_cpu_out_data, t_in_data;
   logic [7:0] t_cpu_in_data, t_out_data;
   logic       t_stall, t_in_ready, t_out_valid, t_timeout_err, t_busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_done = 0;
   int         n_acc = 0;
   logic [7:0] sb_done[$];
   logic [7:0] sb_out[$];
   logic [7:0] m_last = 8'h00;

   always #5 clk = ~clk;

   io_handshake_ctrl dut (
      .clk(clk), .reset(reset), .s_in(s_in), .s_out(s_out),
      .cpu_out_data(cpu_out_data), .cpu_in_data(cpu_in_data), .stall(stall),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .timeout_err(timeout_err), .busy(busy)
   );

   io_handshake_ctrl #(.TO_CYC(4)) dut_t (
      .clk(clk), .reset(reset), .s_in(t_s_in), .s_out(t_s_out),
      .cpu_out_data(t_cpu_out_data), .cpu_in_data(t_cpu_in_data), .stall(t_stall),
      .in_valid(t_in_valid), .in_data(t_in_data), .in_ready(t_in_ready),
      .out_valid(t_out_valid), .out_data(t_out_data), .out_ready(t_out_ready),
      .timeout_err(t_timeout_err), .busy(t_busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: commits at DONE, device-side output transfers, input accepts.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (in_valid && in_ready) n_acc++;
         if (out_valid && out_ready) begin
            if (sb_out.size() == 0) check_val("sb_out_underflow", 1, 0);
            else check_val("out_xfer_data", out_data, sb_out.pop_front());
         end
         if (busy && !stall) begin
            n_done++;
            if (sb_done.size() == 0) check_val("sb_done_underflow", 1, 0);
            else check_val("commit_data", cpu_in_data, sb_done.pop_front());
         end
      end
   end

   // One I/O instruction; the device responds in the n_w-th WAIT cycle.
   task automatic xfer(input string tag, input bit is_in, input bit both,
                       input logic [7:0] d, input int n_w);
      int n_stall = 0;
      bit done = 0;
      if (is_in) begin
         m_last = d;
         in_data = d;
         s_in = 1'b1;
         s_out = both;
         cpu_out_data = 8'hA5;
      end else begin
         s_out = 1'b1;
         cpu_out_data = d;
         sb_out.push_back(d);
      end
      sb_done.push_back(m_last);
      for (int c = 0; c < 60 && !done; c++) begin
         if (is_in) in_valid = (c >= n_w) || (n_w == 1);
         else out_ready = (c >= n_w) || (n_w == 1);
         @(negedge clk);
         if (busy && !stall) begin
            done = 1;
         end else begin
            if (stall) n_stall++;
            if (c == 0) check_val({tag, "_req_idle"}, busy, 0);
            else begin
               check_val({tag, "_in_ready"}, in_ready, is_in);
               check_val({tag, "_out_valid"}, out_valid, !is_in);
               if (!is_in) check_val({tag, "_out_stable"}, out_data, d);
            end
            @(posedge clk); #1;
         end
      end
      if (!done) check_val({tag, "_hang"}, 0, 1);
      check_val({tag, "_stall_cycles"}, n_stall, n_w + 1);
      check_val({tag, "_done_hs"}, {in_ready, out_valid}, 0);
      @(posedge clk); #1;
      s_in = 0; s_out = 0; in_valid = 0; out_ready = 0;
   endtask

   task automatic t_run(input string tag, output int ns);
      bit done = 0;
      ns = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (t_busy && !t_stall) done = 1;
         else begin
            if (t_stall) ns++;
            @(posedge clk); #1;
         end
      end
      if (!done) check_val({tag, "_hang"}, 0, 1);
   endtask

   initial begin
      int a0, d0, ns;
      reset = 1'b1;
      s_in = 0; s_out = 0; in_valid = 0; out_ready = 0; cpu_out_data = 0; in_data = 0;
      t_s_in = 0; t_s_out = 0; t_in_valid = 0; t_out_ready = 0; t_cpu_out_data = 0; t_in_data = 0;
      repeat (2) @(negedge clk);
      check_val("rst_stall", stall, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_cpu_in_data", cpu_in_data, 0);
      check_val("rst_timeout_err", timeout_err, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      xfer("in_5a", 1, 0, 8'h5A, 1);
      @(negedge clk);
      check_val("in_5a_held", cpu_in_data, 8'h5A);
      check_val("in_5a_idle", busy, 0);
      @(posedge clk); #1;

      xfer("out_3c", 0, 0, 8'h3C, 5);
      xfer("both", 1, 1, 8'h66, 2);

      a0 = n_acc;
      d0 = n_done;
      xfer("b2b_1", 1, 0, 8'h01, 1);
      xfer("b2b_2", 1, 0, 8'h02, 1);
      check_val("b2b_accepts", n_acc - a0, 2);
      check_val("b2b_dones", n_done - d0, 2);
      check_val("main_no_timeout", timeout_err, 0);

      check_val("to_err_before", t_timeout_err, 0);
      t_s_in = 1'b1;
      t_run("to", ns);
      check_val("to_stall_cycles", ns, 5);
      check_val("to_data", t_cpu_in_data, 8'hFF);
      check_val("to_err_set", t_timeout_err, 1);
      check_val("to_out_valid", t_out_valid, 0);
      @(posedge clk); #1;
      t_s_in = 1'b0;
      @(posedge clk); #1;
      t_s_in = 1'b1; t_in_valid = 1'b1; t_in_data = 8'h77;
      t_run("to_good", ns);
      check_val("to_good_stall", ns, 2);
      check_val("to_good_data", t_cpu_in_data, 8'h77);
      check_val("to_err_sticky", t_timeout_err, 1);
      check_val("to_out_data", t_out_data, 0);
      @(posedge clk); #1;
      t_s_in = 1'b0; t_in_valid = 1'b0;

      s_out = 1'b1; cpu_out_data = 8'h99;
      repeat (3) @(posedge clk);
      #3;
      check_val("mid_out_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check_val("arst_out_valid", out_valid, 0);
      check_val("arst_stall", stall, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_data_q", cpu_in_data, 0);
      check_val("arst_out_data", out_data, 0);
      s_out = 1'b0;
      m_last = 8'h00;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("post_rst_busy", busy, 0);
      check_val("post_rst_stall", stall, 0);
      @(posedge clk); #1;

      xfer("post_rst", 1, 0, 8'hC3, 3);
      check_val("sb_done_empty", sb_done.size(), 0);
      check_val("sb_out_empty", sb_out.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
